// File: rtl/tx_payload_source.sv
// Fixed-length AXI-Stream test payload source (PRBS-9, counter or 0x55), paced by pkt_sent or free-running.
// First tvalid two cycles after enable; beats stream with no bubbles and hold stable while tready is low.
module tx_payload_source #(
  parameter int unsigned PKT_BYTES  = 16,
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [8:0]  PRBS_SEED  = 9'h1FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  MODE_CTRL,
  input  logic        pkt_sent,
  output logic [7:0]  data_tdata,
  output logic        data_tvalid,
  input  logic        data_tready,
  output logic        data_tlast,
  output logic        data_tuser,
  output logic [15:0] payload_length,
  output logic [15:0] pkt_count
);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_ACK, GAP} state_t;

  localparam logic [15:0] LEN      = 16'(PKT_BYTES);
  localparam logic [15:0] LAST_IDX = 16'(PKT_BYTES - 1);
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
  localparam bit          GAP_NONE = (GAP_CYCLES == 0);

  state_t      state, state_nxt, after_gap;
  logic [15:0] idx, gap_cnt;
  logic [8:0]  lfsr, prbs_adv;
  logic [7:0]  cnt, prbs_byte, pat_byte;
  logic [2:0]  mode;
  logic [1:0]  pat_sel;
  logic        hs, last_hs, gen;

  assign data_tvalid = (state == SEND);
  assign data_tuser  = data_tvalid && (idx == 16'd0);
  assign data_tlast  = data_tvalid && (idx == LAST_IDX);
  assign hs          = data_tvalid && data_tready;
  assign last_hs     = hs && data_tlast;
  assign after_gap   = MODE_CTRL[3] ? LOAD : IDLE;

  // lfsr/cnt always hold the state for the byte after the one on tdata, so
  // nothing advances on the tlast beat and the sequence resumes seamlessly.
  assign pat_sel = (state == LOAD) ? MODE_CTRL[1:0] : mode[1:0];
  assign gen     = (state == LOAD) || (hs && !data_tlast);

  always_comb begin
    prbs_adv  = lfsr;
    prbs_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      prbs_byte[7-i] = prbs_adv[8];
      prbs_adv       = {prbs_adv[7:0], prbs_adv[8] ^ prbs_adv[4]};
    end
  end

  always_comb begin
    case (pat_sel)
      2'b00:   pat_byte = prbs_byte;
      2'b01:   pat_byte = cnt;
      default: pat_byte = 8'h55;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (MODE_CTRL[3]) state_nxt = LOAD;
      LOAD:     state_nxt = SEND;
      SEND:     if (last_hs) state_nxt = mode[2] ? (GAP_NONE ? after_gap : GAP) : WAIT_ACK;
      WAIT_ACK: if (pkt_sent) state_nxt = GAP_NONE ? after_gap : GAP;
      GAP:      if (gap_cnt == GAP_LAST) state_nxt = after_gap;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= 16'd0;
      gap_cnt        <= 16'd0;
      lfsr           <= PRBS_SEED;
      cnt            <= 8'd0;
      mode           <= 3'd0;
      data_tdata     <= 8'h00;
      payload_length <= 16'd0;
      pkt_count      <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && MODE_CTRL[3]) begin
        lfsr <= PRBS_SEED;
        cnt  <= 8'd0;
      end
      if (state == LOAD) begin
        mode           <= MODE_CTRL[2:0];
        payload_length <= LEN;
        idx            <= 16'd0;
      end else if (hs) begin
        idx <= idx + 16'd1;
      end
      if (gen) begin
        data_tdata <= pat_byte;
        if (pat_sel == 2'b00) lfsr <= prbs_adv;
        if (pat_sel == 2'b01) cnt <= cnt + 8'd1;
      end
      if (last_hs) pkt_count <= pkt_count + 16'd1;
      if (state_nxt == GAP && state != GAP) gap_cnt <= 16'd0;
      else if (state == GAP) gap_cnt <= gap_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_tx_payload_source.sv
// Bench for tx_payload_source: 16-byte/gap-4 instance plus a 1-byte/gap-0 instance,
// random tready/pkt_sent, expected bytes from a PRBS bit-recurrence and counter arithmetic.
module tb_tx_payload_source;
  localparam int         PKT  = 16;
  localparam int         GAP  = 4;
  localparam logic [8:0] SEED = 9'h1FF;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] mode_ctrl = 4'd0, mode1 = 4'd0;
  logic pkt_sent = 1'b0, pkt_sent1 = 1'b0, tready = 1'b0, tready1 = 1'b0;
  logic [7:0] tdata, tdata1;
  logic tvalid, tvalid1, tlast, tlast1, tuser, tuser1;
  logic [15:0] plen, plen1, pcnt, pcnt1;

  tx_payload_source #(.PKT_BYTES(PKT), .GAP_CYCLES(GAP), .PRBS_SEED(SEED)) u16 (
    .clk(clk), .rst_n(rst_n), .MODE_CTRL(mode_ctrl), .pkt_sent(pkt_sent),
    .data_tdata(tdata), .data_tvalid(tvalid), .data_tready(tready), .data_tlast(tlast),
    .data_tuser(tuser), .payload_length(plen), .pkt_count(pcnt));

  tx_payload_source #(.PKT_BYTES(1), .GAP_CYCLES(0), .PRBS_SEED(SEED)) u1 (
    .clk(clk), .rst_n(rst_n), .MODE_CTRL(mode1), .pkt_sent(pkt_sent1),
    .data_tdata(tdata1), .data_tvalid(tvalid1), .data_tready(tready1), .data_tlast(tlast1),
    .data_tuser(tuser1), .payload_length(plen1), .pkt_count(pcnt1));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;

  // PRBS-9 output sequence: o[n+9] = o[n] ^ o[n+4], first nine bits are the seed MSB first.
  bit prbs_o [0:2047];
  function automatic logic [7:0] prbs_ref(input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = prbs_o[8*k+j];
    return b;
  endfunction

  logic [7:0] got_dat[$];
  logic       got_usr[$], got_lst[$];
  int         got_cyc[$];
  int         stall_err = 0;
  bit         rand_sent = 0;
  logic [10:0] prev_obs;
  bit          prev_stall = 0;

  task automatic clear_beats();
    got_dat.delete(); got_usr.delete(); got_lst.delete(); got_cyc.delete();
    prev_stall = 0;
  endtask

  // Steps negedges, randomises tready, records accepted beats and stall violations.
  task automatic collect(input int nbeats, input int pct, input int budget);
    int got = 0, t = 0;
    logic rdy;
    while (got < nbeats && t < budget) begin
      @(negedge clk); t++;
      if (prev_stall && {tvalid, tdata, tuser, tlast} !== prev_obs) stall_err++;
      rdy = ($urandom_range(99) < pct);
      tready = rdy;
      pkt_sent = rand_sent ? 1'($urandom_range(1)) : 1'b0;
      if (tvalid && rdy) begin
        got_dat.push_back(tdata); got_usr.push_back(tuser);
        got_lst.push_back(tlast); got_cyc.push_back(cyc);
        got++;
      end
      prev_stall = tvalid && !rdy;
      prev_obs   = {tvalid, tdata, tuser, tlast};
    end
  endtask

  task automatic pulse_sent();
    @(negedge clk); pkt_sent = 1'b1;
    @(negedge clk); pkt_sent = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++; if ({tvalid, tuser, tlast} !== 3'b000) $display("FAIL reset_ctl: got %b want 000", {tvalid, tuser, tlast}); else n_pass++;
    n_total++; if (tdata !== 8'h00) $display("FAIL reset_tdata: got %h want 00", tdata); else n_pass++;
    n_total++; if (plen !== 16'd0 || pcnt !== 16'd0) $display("FAIL reset_len_cnt: got %h/%h want 0/0", plen, pcnt); else n_pass++;
    n_total++; if ({tvalid1, pcnt1} !== 17'd0) $display("FAIL reset_u1: got %h want 0", {tvalid1, pcnt1}); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_prbs_paced();
    int c0, cp, quiet;
    clear_beats();
    @(negedge clk); mode_ctrl = 4'b1000; tready = 1'b1; c0 = cyc;
    collect(PKT, 100, 40);
    n_total++; if (got_dat.size() != PKT) $display("FAIL prbs_beats: got %0d want %0d", got_dat.size(), PKT); else n_pass++;
    n_total++; if (got_cyc.size() > 0 && got_cyc[0] - c0 != 2) $display("FAIL prbs_latency: got %0d want 2", got_cyc[0] - c0); else n_pass++;
    n_total++; if (got_dat.size() > 1 && {got_dat[0], got_dat[1]} !== 16'hFF83) $display("FAIL prbs_first: got %h %h want ff 83", got_dat[0], got_dat[1]); else n_pass++;
    for (int i = 0; i < got_dat.size(); i++) begin
      n_total++;
      if ({got_dat[i], got_usr[i], got_lst[i]} !== {prbs_ref(i), i == 0, i == PKT - 1})
        $display("FAIL prbs_beat%0d: got %h/%b/%b want %h/%b/%b", i, got_dat[i], got_usr[i], got_lst[i], prbs_ref(i), i == 0, i == PKT - 1);
      else n_pass++;
    end
    n_total++; if (got_cyc.size() == PKT && got_cyc[PKT-1] - got_cyc[0] != PKT - 1) $display("FAIL prbs_stream: got span %0d want %0d", got_cyc[PKT-1] - got_cyc[0], PKT - 1); else n_pass++;
    quiet = 0;
    repeat (10) begin @(negedge clk); if (tvalid) quiet++; end
    n_total++; if (quiet != 0) $display("FAIL wait_ack_quiet: got %0d valid cycles want 0", quiet); else n_pass++;
    n_total++; if (pcnt !== 16'd1 || plen !== 16'(PKT)) $display("FAIL prbs_counts: got %0d/%0d want 1/%0d", pcnt, plen, PKT); else n_pass++;
    @(negedge clk); pkt_sent = 1'b1; cp = cyc;
    clear_beats();
    collect(PKT, 100, 40);
    n_total++; if (got_cyc.size() > 0 && got_cyc[0] - cp != GAP + 2) $display("FAIL sent_to_valid: got %0d want %0d", got_cyc[0] - cp, GAP + 2); else n_pass++;
    for (int i = 0; i < got_dat.size(); i++) begin
      n_total++;
      if (got_dat[i] !== prbs_ref(PKT + i)) $display("FAIL prbs2_beat%0d: got %h want %h", i, got_dat[i], prbs_ref(PKT + i));
      else n_pass++;
    end
    @(negedge clk); mode_ctrl = 4'b0000;
    pulse_sent();
    repeat (GAP + 4) @(negedge clk);
  endtask

  task automatic test_free_run_counter();
    int quiet;
    logic [15:0] pc0;
    clear_beats(); pc0 = pcnt;
    @(negedge clk); mode_ctrl = 4'b1101; rand_sent = 1;
    collect(3 * PKT, 100, 200);
    rand_sent = 0; pkt_sent = 1'b0; mode_ctrl = 4'b0000;
    n_total++; if (got_dat.size() != 3 * PKT) $display("FAIL cnt_beats: got %0d want %0d", got_dat.size(), 3 * PKT); else n_pass++;
    for (int i = 0; i < got_dat.size(); i++) begin
      n_total++;
      if ({got_dat[i], got_usr[i], got_lst[i]} !== {8'(i), (i % PKT) == 0, (i % PKT) == PKT - 1})
        $display("FAIL cnt_beat%0d: got %h/%b/%b want %h", i, got_dat[i], got_usr[i], got_lst[i], 8'(i));
      else n_pass++;
    end
    for (int p = 1; p < 3; p++) begin
      n_total++;
      if (got_cyc.size() == 3 * PKT && got_cyc[p*PKT] - got_cyc[p*PKT-1] != GAP + 2)
        $display("FAIL free_gap%0d: got %0d want %0d", p, got_cyc[p*PKT] - got_cyc[p*PKT-1], GAP + 2);
      else n_pass++;
    end
    repeat (GAP + 4) @(negedge clk);
    quiet = 0;
    repeat (8) begin @(negedge clk); if (tvalid) quiet++; end
    n_total++; if (quiet != 0) $display("FAIL free_stop: got %0d valid cycles want 0", quiet); else n_pass++;
    n_total++; if (pcnt !== pc0 + 16'd3) $display("FAIL free_pcnt: got %0d want %0d", pcnt, pc0 + 16'd3); else n_pass++;
  endtask

  task automatic test_random_stall();
    clear_beats(); stall_err = 0;
    @(negedge clk); mode_ctrl = 4'b1001;
    collect(5, 50, 200);
    mode_ctrl = 4'b1010;
    collect(PKT - 5, 50, 400);
    n_total++; if (got_dat.size() != PKT) $display("FAIL stall_beats: got %0d want %0d", got_dat.size(), PKT); else n_pass++;
    for (int i = 0; i < got_dat.size(); i++) begin
      n_total++;
      if ({got_dat[i], got_usr[i], got_lst[i]} !== {8'(i), i == 0, i == PKT - 1})
        $display("FAIL stall_beat%0d: got %h/%b/%b want %h", i, got_dat[i], got_usr[i], got_lst[i], 8'(i));
      else n_pass++;
    end
    n_total++; if (stall_err != 0) $display("FAIL stall_stable: got %0d violations want 0", stall_err); else n_pass++;
    pulse_sent();
    clear_beats();
    collect(PKT, 100, 60);
    n_total++; if (got_dat.size() != PKT) $display("FAIL const_beats: got %0d want %0d", got_dat.size(), PKT); else n_pass++;
    for (int i = 0; i < got_dat.size(); i++) begin
      n_total++;
      if (got_dat[i] !== 8'h55) $display("FAIL const_beat%0d: got %h want 55", i, got_dat[i]); else n_pass++;
    end
    @(negedge clk); mode_ctrl = 4'b0000;
    pulse_sent();
    repeat (GAP + 4) @(negedge clk);
  endtask

  task automatic test_enable_drop();
    int quiet;
    clear_beats(); stall_err = 0;
    @(negedge clk); mode_ctrl = 4'b1000;
    collect(5, 100, 40);
    mode_ctrl = 4'b0000;
    collect(PKT - 5, 70, 200);
    n_total++; if (got_dat.size() != PKT) $display("FAIL drop_beats: got %0d want %0d", got_dat.size(), PKT); else n_pass++;
    for (int i = 0; i < got_dat.size(); i++) begin
      n_total++;
      if ({got_dat[i], got_lst[i]} !== {prbs_ref(i), i == PKT - 1})
        $display("FAIL drop_beat%0d: got %h/%b want %h/%b", i, got_dat[i], got_lst[i], prbs_ref(i), i == PKT - 1);
      else n_pass++;
    end
    quiet = 0;
    repeat (6) begin @(negedge clk); if (tvalid) quiet++; end
    pulse_sent();
    repeat (GAP + 10) begin @(negedge clk); if (tvalid) quiet++; end
    n_total++; if (quiet != 0) $display("FAIL drop_idle: got %0d valid cycles want 0", quiet); else n_pass++;
  endtask

  task automatic test_single_byte();
    int beats = 0, c_first = -1, c_second = -1;
    @(negedge clk); mode1 = 4'b1110; tready1 = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tvalid1) begin
        beats++;
        if (c_first < 0) c_first = cyc; else if (c_second < 0) c_second = cyc;
        n_total++;
        if ({tdata1, tuser1, tlast1} !== {8'h55, 1'b1, 1'b1}) $display("FAIL one_beat%0d: got %h/%b/%b want 55/1/1", beats, tdata1, tuser1, tlast1);
        else n_pass++;
      end
    end
    mode1 = 4'b0000;
    repeat (6) begin @(negedge clk); if (tvalid1) beats++; end
    n_total++; if (pcnt1 !== 16'(beats)) $display("FAIL one_pcnt: got %0d want %0d", pcnt1, beats); else n_pass++;
    n_total++; if (c_second - c_first != 2) $display("FAIL one_spacing: got %0d want 2", c_second - c_first); else n_pass++;
  endtask

  task automatic test_wrap();
    @(negedge clk); force u1.pkt_count = 16'hFFFF;
    @(negedge clk); release u1.pkt_count;
    @(negedge clk);
    n_total++; if (pcnt1 !== 16'hFFFF) $display("FAIL wrap_preset: got %h want ffff", pcnt1); else n_pass++;
    mode1 = 4'b1110;
    @(negedge clk); mode1 = 4'b0000;
    repeat (4) @(negedge clk);
    n_total++; if (pcnt1 !== 16'h0000) $display("FAIL wrap: got %h want 0000", pcnt1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_beats();
    @(negedge clk); mode_ctrl = 4'b1000;
    collect(7, 100, 40);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({tvalid, tuser, tlast, tdata} !== 11'd0) $display("FAIL rst_mid_out: got %h want 000", {tvalid, tuser, tlast, tdata}); else n_pass++;
    n_total++; if ({pcnt, plen} !== 32'd0) $display("FAIL rst_mid_cnt: got %h want 0", {pcnt, plen}); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    clear_beats();
    collect(1, 100, 40);
    n_total++; if (got_dat.size() != 1 || {got_dat[0], got_usr[0]} !== {8'hFF, 1'b1}) $display("FAIL rst_restart: got %0d beats want ff/1", got_dat.size()); else n_pass++;
    n_total++; if (pcnt !== 16'd0) $display("FAIL rst_restart_cnt: got %0d want 0", pcnt); else n_pass++;
    mode_ctrl = 4'b0000;
    repeat (PKT + 2) @(negedge clk);
  endtask

  initial begin
    logic [8:0] s;
    s = SEED;
    for (int i = 0; i < 9; i++) prbs_o[i] = s[8-i];
    for (int n = 0; n + 9 < 2048; n++) prbs_o[n+9] = prbs_o[n] ^ prbs_o[n+4];
    repeat (2) @(negedge clk);
    test_reset();
    test_prbs_paced();
    test_free_run_counter();
    test_random_stall();
    test_enable_drop();
    test_single_byte();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
